fetch_pc_unit: RTL and testbench

- Owns the program counter and instruction register of the 16-bit multicycle core; sits directly upstream of the main control FSM.
- Supplies op/func to the FSM and executes the FSM's PCwrt/IRwrt/branch/jump/BNEoBEQ commands.
- Runs a req/ack handshake with instruction memory and stalls the FSM's FETCH state until the instruction is latched.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/pc_next_calc.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 129 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multicycle core:
// opcodes, func codes, jump encodings and fetch states.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_BEQ   = 4'd2;
  localparam logic [3:0] OP_BNE   = 4'd3;
  localparam logic [3:0] OP_J     = 4'd4;
  localparam logic [3:0] OP_LW    = 4'd5;
  localparam logic [3:0] OP_SW    = 4'd6;
  localparam logic [3:0] OP_LI    = 4'd8;

  localparam logic [3:0] FN_COPY = 4'd6;
  localparam logic [3:0] FN_JR   = 4'd7;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_DIR  = 2'b01;
  localparam logic [1:0] JMP_REG  = 2'b10;
  localparam logic [1:0] JMP_RSV  = 2'b11;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int FN_HI  = 3;
  localparam int FN_LO  = 0;
  localparam int JT_HI  = 11;
  localparam int IMM_HI = 7;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DONE
  } fetch_state_t;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: increment, jr,
// direct jump and conditional branch.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [11:0] ir_lo,
  input  logic [15:0] jr_target,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        bne,
  input  logic        alu_zero,
  output logic [15:0] pc_inc,
  output logic [15:0] pc_redir,
  output logic        taken,
  output logic        redirect,
  output logic        illegal
);

  assign pc_inc   = pc + 16'd1;
  assign taken    = branch & (alu_zero ^ bne);
  assign redirect = branch | (jump != JMP_NONE);
  assign illegal  = (jump == JMP_RSV);

  // jr beats direct jump beats branch; reserved jump holds pc
  always_comb begin
    pc_redir = pc;
    unique case (1'b1)
      jump == JMP_REG:
        pc_redir = jr_target;
      jump == JMP_DIR:
        pc_redir = {pc[15:12], ir_lo};
      (jump == JMP_NONE) && taken:
        pc_redir = pc + sext8(ir_lo[IMM_HI:0]);
      default:
        pc_redir = pc;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC and IR owner for the multicycle core; runs the imem
// req/ack handshake and executes control's redirects.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] NOP_INSTR = 16'h1000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        PCwrt,
  input  logic        IRwrt,
  input  logic        branch,
  input  logic        BNEoBEQ,
  input  logic [1:0]  jump,
  input  logic        alu_zero,
  input  logic [15:0] jr_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic [3:0]  op,
  output logic [3:0]  func,
  output logic [15:0] pc,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fetch_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   pc_n, ir_n, addr_n;
  logic          req_n, err_n;
  logic [15:0]   pc_inc, pc_redir;
  logic          taken, redirect, illegal;
  logic          fetch_start;

  assign fetch_start = PCwrt & IRwrt;
  assign op          = ir[OP_HI:OP_LO];
  assign func        = ir[FN_HI:FN_LO];
  assign fetch_busy  = ((state == F_IDLE) & fetch_start)
                     | (state == F_REQ);

  pc_next_calc u_next (
    .pc        (pc),
    .ir_lo     (ir[JT_HI:0]),
    .jr_target (jr_target),
    .jump      (jump),
    .branch    (branch),
    .bne       (BNEoBEQ),
    .alu_zero  (alu_zero),
    .pc_inc    (pc_inc),
    .pc_redir  (pc_redir),
    .taken     (taken),
    .redirect  (redirect),
    .illegal   (illegal)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= F_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      fetch_err <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      fetch_err <= err_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    req_n   = imem_req;
    addr_n  = imem_addr;
    err_n   = fetch_err;
    cnt_n   = cnt;
    unique case (state)
      F_IDLE: begin
        if (fetch_start) begin
          state_n = F_REQ;
          req_n   = 1'b1;
          addr_n  = pc;
          cnt_n   = '0;
          err_n   = fetch_err | redirect;
        end else if (redirect) begin
          pc_n  = pc_redir;
          err_n = fetch_err | illegal;
        end
      end
      F_REQ: begin
        err_n = fetch_err | redirect | fetch_start;
        if (imem_ack) begin
          ir_n    = imem_rdata;
          pc_n    = pc_inc;
          req_n   = 1'b0;
          state_n = F_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          ir_n    = NOP_INSTR;
          pc_n    = pc_inc;
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = F_DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // control still holds PCwrt/IRwrt here
      F_DONE: begin
        err_n   = fetch_err | redirect;
        state_n = F_IDLE;
      end
      default: state_n = F_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected IR/PC/err
// entries are queued at stimulus and popped at completion.
module tb_fetch_pc_unit;

  localparam int          TMO = 15;
  localparam logic [15:0] NOP = 16'h1000;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        PCwrt = 1'b0;
  logic        IRwrt = 1'b0;
  logic        branch = 1'b0;
  logic        BNEoBEQ = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic        alu_zero = 1'b0;
  logic [15:0] jr_target = '0;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        imem_req, fetch_busy, fetch_err;
  logic [15:0] imem_addr, ir, pc;
  logic [3:0]  op, func;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] m_pc, m_ir;
  logic        m_err;

  fetch_pc_unit #(
    .RESET_PC  (16'h0000),
    .TIMEOUT   (TMO),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .PCwrt      (PCwrt),
    .IRwrt      (IRwrt),
    .branch     (branch),
    .BNEoBEQ    (BNEoBEQ),
    .jump       (jump),
    .alu_zero   (alu_zero),
    .jr_target  (jr_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .op         (op),
    .func       (func),
    .pc         (pc),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 CLK = ~CLK;

  task automatic do_redirect(input string nm, input logic [1:0] j,
                             input logic b, input logic bne,
                             input logic z, input logic [15:0] jt,
                             input logic [15:0] exp_pc,
                             input logic exp_ill);
    exp_t e;
    jump = j; branch = b; BNEoBEQ = bne;
    alu_zero = z; jr_target = jt;
    sb.push_back('{ir: m_ir, pc: exp_pc, err: m_err | exp_ill});
    @(posedge CLK); #1;
    jump = 2'b00; branch = 1'b0; BNEoBEQ = 1'b0; alu_zero = 1'b0;
    e = sb.pop_front();
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("FAIL %s pc: got %h want %h", nm, pc, e.pc);
    end
    checks++;
    if (fetch_err !== e.err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", nm, fetch_err, e.err);
    end
    checks++;
    if (ir !== e.ir) begin
      errors++;
      $display("FAIL %s ir: got %h want %h", nm, ir, e.ir);
    end
    m_pc = e.pc; m_err = e.err;
  endtask

  // delay = REQ cycle in which ack is given; 0 = never
  task automatic do_fetch(input string nm, input logic [15:0] rdata,
                          input int delay, input logic [1:0] j,
                          input logic [15:0] jt);
    exp_t e;
    int n, busy, exp_n;
    logic [15:0] addr;
    logic addr_bad;
    addr = m_pc;
    addr_bad = 1'b0;
    exp_n = (delay == 0) ? TMO : delay;
    sb.push_back('{ir: (delay == 0) ? NOP : rdata,
                   pc: m_pc + 16'd1,
                   err: m_err | (delay == 0) | (j != 2'b00)});
    PCwrt = 1'b1; IRwrt = 1'b1; jump = j; jr_target = jt;
    #1;
    busy = fetch_busy ? 1 : 0;
    @(posedge CLK); #1;
    PCwrt = 1'b0; IRwrt = 1'b0; jump = 2'b00;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      errors++;
      $display("FAIL %s req: got req=%b addr=%h want 1 %h",
               nm, imem_req, imem_addr, addr);
    end
    n = 0;
    for (int i = 0; i < TMO + 4 && imem_req === 1'b1; i++) begin
      imem_ack = (delay == n + 1);
      imem_rdata = imem_ack ? rdata : 16'hDEAD;
      #1;
      if (fetch_busy) busy++;
      @(posedge CLK); #1;
      n++;
      if (imem_req === 1'b1 && imem_addr !== addr) addr_bad = 1'b1;
    end
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || n !== exp_n || addr_bad) begin
      errors++;
      $display("FAIL %s req_len: got %0d cycles req=%b addr_bad=%b want %0d",
               nm, n, imem_req, addr_bad, exp_n);
    end
    checks++;
    if (busy !== exp_n + 1) begin
      errors++;
      $display("FAIL %s busy: got %0d want %0d", nm, busy, exp_n + 1);
    end
    // control still asserts fetch in DONE: ignored, no error
    PCwrt = 1'b1; IRwrt = 1'b1;
    #1;
    checks++;
    if (fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_busy: got %b want 0", nm, fetch_busy);
    end
    @(posedge CLK); #1;
    PCwrt = 1'b0; IRwrt = 1'b0;
    e = sb.pop_front();
    checks++;
    if (ir !== e.ir || op !== e.ir[15:12] || func !== e.ir[3:0]) begin
      errors++;
      $display("FAIL %s ir: got %h op=%h func=%h want %h",
               nm, ir, op, func, e.ir);
    end
    checks++;
    if (pc !== e.pc) begin
      errors++;
      $display("FAIL %s pc: got %h want %h", nm, pc, e.pc);
    end
    checks++;
    if (fetch_err !== e.err || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s err: got %b req=%b want %b 0",
               nm, fetch_err, imem_req, e.err);
    end
    m_pc = e.pc; m_ir = e.ir; m_err = e.err;
  endtask

  task automatic test_reset();
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pc !== 16'h0000 || ir !== 16'h0000 || imem_req !== 1'b0 ||
        imem_addr !== 16'h0000 || fetch_err !== 1'b0 ||
        fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pc=%h ir=%h req=%b addr=%h err=%b busy=%b want all 0",
               pc, ir, imem_req, imem_addr, fetch_err, fetch_busy);
    end
    @(negedge CLK) reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    imem_ack = 1'b0;
    checks++;
    if (ir !== 16'h0000 || imem_req !== 1'b0 || pc !== 16'h0000) begin
      errors++;
      $display("FAIL stale_ack: got ir=%h req=%b pc=%h want 0 0 0",
               ir, imem_req, pc);
    end
    m_pc = 16'h0000; m_ir = 16'h0000; m_err = 1'b0;
    sb.delete();
  endtask

  task automatic test_fetch();
    do_fetch("fetch_basic", 16'h5123, 1, 2'b00, 16'h0000);
  endtask

  task automatic test_fetch_delayed();
    do_fetch("fetch_delay5", 16'h0017, 5, 2'b00, 16'h0000);
  endtask

  task automatic test_branch();
    do_redirect("br_setup_jr", 2'b10, 0, 0, 0, 16'h000F, 16'h000F, 0);
    do_fetch("br_setup_fetch", 16'h20FE, 1, 2'b00, 16'h0000);
    do_redirect("beq_taken", 2'b00, 1, 0, 1, 16'h0, 16'h000E, 0);
    do_redirect("br_rewind", 2'b10, 0, 0, 0, 16'h0010, 16'h0010, 0);
    do_redirect("beq_not", 2'b00, 1, 0, 0, 16'h0, 16'h0010, 0);
    do_redirect("bne_taken", 2'b00, 1, 1, 0, 16'h0, 16'h000E, 0);
    do_redirect("bne_not", 2'b00, 1, 1, 1, 16'h0, 16'h000E, 0);
  endtask

  task automatic test_jump();
    do_redirect("j_setup_jr", 2'b10, 0, 0, 0, 16'h3004, 16'h3004, 0);
    do_fetch("j_setup_fetch", 16'h4ABC, 1, 2'b00, 16'h0000);
    do_redirect("j_direct", 2'b01, 0, 0, 0, 16'h0, 16'h3ABC, 0);
    do_redirect("j_reg", 2'b10, 0, 0, 0, 16'h1234, 16'h1234, 0);
    do_redirect("j_reserved", 2'b11, 0, 0, 0, 16'hFFFF, 16'h1234, 1);
  endtask

  task automatic test_timeout();
    do_redirect("tmo_setup", 2'b10, 0, 0, 0, 16'h0040, 16'h0040, 0);
    do_fetch("timeout", 16'h9999, 0, 2'b00, 16'h0000);
  endtask

  task automatic test_wrap();
    do_redirect("wrap_setup", 2'b10, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0);
    do_fetch("pc_wrap", 16'h8001, 2, 2'b00, 16'h0000);
  endtask

  task automatic test_collision();
    do_fetch("fetch_vs_jr", 16'h6006, 1, 2'b10, 16'h5555);
  endtask

  task automatic test_reset_mid_req();
    PCwrt = 1'b1; IRwrt = 1'b1;
    @(posedge CLK); #1;
    PCwrt = 1'b0; IRwrt = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL midreq_pre: got req=%b want 1", imem_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 16'h0000 || ir !== 16'h0000) begin
      errors++;
      $display("FAIL midreq_reset: got req=%b pc=%h ir=%h want 0 0 0",
               imem_req, pc, ir);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h7777;
    @(negedge CLK) reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    imem_ack = 1'b0;
    checks++;
    if (ir !== 16'h0000 || pc !== 16'h0000 || imem_req !== 1'b0 ||
        fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: got ir=%h pc=%h req=%b busy=%b want 0 0 0 0",
               ir, pc, imem_req, fetch_busy);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_fetch_delayed();
    test_branch();
    test_jump();
    test_reset();
    test_timeout();
    test_reset();
    test_wrap();
    test_reset();
    test_collision();
    test_reset();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
